// File: rtl/sinaleira_monitor.sv
// Traffic-light sequence monitor: decodes eight lamp inputs into a phase and flags illegal
// lamp patterns, bad transitions and wrong dwell times. Optional counters: SINALEIRA_MONITOR_STATS_EN.
module sinaleira_monitor #(
    parameter int T_S1G    = 1,
    parameter int T_YEL    = 2,
    parameter int T_S2G    = 4,
    parameter int T_PED    = 5,
    parameter int T_ALLRED = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rua_1_vermelho,
    input  logic       rua_1_amarelo,
    input  logic       rua_1_verde,
    input  logic       rua_2_vermelho,
    input  logic       rua_2_amarelo,
    input  logic       rua_2_verde,
    input  logic       pedestre_vermelho,
    input  logic       pedestre_verde,
    input  logic       clr_fault,
    output logic [2:0] phase,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       ped_served
`ifdef SINALEIRA_MONITOR_STATS_EN
    ,
    output logic [7:0] cycle_count,
    output logic [7:0] ped_count
`endif
);

    typedef enum logic [2:0] {
        PH_ALLRED  = 3'd0,
        PH_S1G     = 3'd1,
        PH_S1Y     = 3'd2,
        PH_S2G     = 3'd3,
        PH_S2Y     = 3'd4,
        PH_PG      = 3'd5,
        PH_ILLEGAL = 3'd7
    } phase_t;

    typedef enum logic {SYNC, TRACK} state_t;

    localparam logic [3:0] REQ_S1G    = 4'(T_S1G);
    localparam logic [3:0] REQ_YEL    = 4'(T_YEL);
    localparam logic [3:0] REQ_S2G    = 4'(T_S2G);
    localparam logic [3:0] REQ_PED    = 4'(T_PED);
    localparam logic [3:0] REQ_ALLRED = 4'(T_ALLRED);

    logic [7:0] lamps;
    phase_t     cur;
    phase_t     prev_decode;
    phase_t     last_phase;
    state_t     state;
    logic [3:0] dwell;
    logic       allred_timed;
    logic [3:0] req;
    logic       req_known;
    logic [1:0] new_code;
    logic       load;
    logic       inc;
    logic       served;
    logic       cycle_done;

    assign lamps = {rua_1_vermelho, rua_1_amarelo, rua_1_verde,
                    rua_2_vermelho, rua_2_amarelo, rua_2_verde,
                    pedestre_vermelho, pedestre_verde};

    function automatic logic step_ok(input phase_t from, input phase_t to);
        case (from)
            PH_ALLRED: step_ok = (to == PH_S1G);
            PH_S1G:    step_ok = (to == PH_S1Y);
            PH_S1Y:    step_ok = (to == PH_S2G);
            PH_S2G:    step_ok = (to == PH_S2Y);
            PH_S2Y:    step_ok = (to == PH_S1G) || (to == PH_PG);
            PH_PG:     step_ok = (to == PH_ALLRED);
            default:   step_ok = 1'b0;
        endcase
    endfunction

    always_comb begin
        case (lamps)
            8'b100_100_10: cur = PH_ALLRED;
            8'b001_100_10: cur = PH_S1G;
            8'b010_100_10: cur = PH_S1Y;
            8'b100_001_10: cur = PH_S2G;
            8'b100_010_10: cur = PH_S2Y;
            8'b100_100_01: cur = PH_PG;
            default:       cur = PH_ILLEGAL;
        endcase
    end

    // ALLRED only has a required dwell when it was entered from pedestrian green
    always_comb begin
        req       = 4'd15;
        req_known = 1'b1;
        case (last_phase)
            PH_S1G:    req = REQ_S1G;
            PH_S1Y:    req = REQ_YEL;
            PH_S2G:    req = REQ_S2G;
            PH_S2Y:    req = REQ_YEL;
            PH_PG:     req = REQ_PED;
            PH_ALLRED: begin
                req       = REQ_ALLRED;
                req_known = allred_timed;
            end
            default:   req_known = 1'b0;
        endcase
    end

    always_comb begin
        new_code   = 2'b00;
        load       = 1'b0;
        inc        = 1'b0;
        served     = 1'b0;
        cycle_done = 1'b0;
        if (cur == PH_ILLEGAL) begin
            new_code = 2'b01;
        end else if (state == SYNC) begin
            load = (cur != prev_decode);
        end else if (cur == last_phase) begin
            if (req_known && dwell >= req) new_code = 2'b11;
            else                           inc = 1'b1;
        end else if (req_known && dwell < req) begin
            new_code = 2'b11;
        end else if (!step_ok(last_phase, cur)) begin
            new_code = 2'b10;
        end else begin
            load       = 1'b1;
            served     = (last_phase == PH_PG);
            cycle_done = served || (last_phase == PH_S2Y && cur == PH_S1G);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= 3'd0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
            ped_served   <= 1'b0;
            dwell        <= 4'd0;
            state        <= SYNC;
            prev_decode  <= PH_ILLEGAL;
            last_phase   <= PH_ALLRED;
            allred_timed <= 1'b0;
        end else begin
            prev_decode <= cur;
            phase       <= cur;
            ped_served  <= served;
            if (new_code != 2'b00) begin
                state <= SYNC;
                fault <= 1'b1;
                // Only the first fault is recorded unless it is being cleared this cycle
                if (!fault || clr_fault) fault_code <= new_code;
            end else begin
                if (clr_fault) begin
                    fault      <= 1'b0;
                    fault_code <= 2'b00;
                end
                if (load) begin
                    state        <= TRACK;
                    last_phase   <= cur;
                    dwell        <= 4'd1;
                    allred_timed <= (state == TRACK) && (last_phase == PH_PG);
                end else if (inc) begin
                    dwell <= (dwell == 4'd15) ? 4'd15 : dwell + 4'd1;
                end
            end
        end
    end

`ifdef SINALEIRA_MONITOR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 8'd0;
            ped_count   <= 8'd0;
        end else begin
            if (cycle_done) cycle_count <= cycle_count + 8'd1;
            if (ped_served) ped_count   <= ped_count + 8'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = cycle_done;
`endif

endmodule

// File: tb/tb_sinaleira_monitor.sv
// Randomised and directed bench for sinaleira_monitor, compared against a phase-run model.
module tb_sinaleira_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic r1v = 0, r1a = 0, r1g = 0, r2v = 0, r2a = 0, r2g = 0, pv = 0, pg = 0;
    logic clr_fault = 1'b0;
    logic [2:0] phase;
    logic fault;
    logic [1:0] fault_code;
    logic ped_served;
`ifdef SINALEIRA_MONITOR_STATS_EN
    logic [7:0] cycle_count;
    logic [7:0] ped_count;
`endif

    sinaleira_monitor dut (
        .clk(clk), .reset(reset),
        .rua_1_vermelho(r1v), .rua_1_amarelo(r1a), .rua_1_verde(r1g),
        .rua_2_vermelho(r2v), .rua_2_amarelo(r2a), .rua_2_verde(r2g),
        .pedestre_vermelho(pv), .pedestre_verde(pg),
        .clr_fault(clr_fault),
        .phase(phase), .fault(fault), .fault_code(fault_code), .ped_served(ped_served)
`ifdef SINALEIRA_MONITOR_STATS_EN
        , .cycle_count(cycle_count), .ped_count(ped_count)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [7:0] PATS [6] = '{8'b10010010, 8'b00110010, 8'b01010010,
                                        8'b10000110, 8'b10001010, 8'b10010001};
    localparam int REQ [6] = '{1, 1, 2, 4, 2, 5};
    localparam int STEPS [7] = '{1, 12, 23, 34, 41, 45, 50};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the run of identical phases currently being timed, plus expected outputs
    int m_prev, m_run, m_len, m_cycles, m_peds;
    bit m_track, m_timed;
    int e_phase, e_code;
    bit e_fault, e_ped;

    logic [6:0] obs;
    assign obs = {phase, fault, fault_code, ped_served};

    function automatic logic [6:0] expv();
        return {3'(e_phase), e_fault, 2'(e_code), e_ped};
    endfunction

    function automatic logic [7:0] pat(input int ph);
        return PATS[ph];
    endfunction

    function automatic int decode_model(input logic [7:0] l);
        int r = 7;
        for (int k = 0; k < 6; k++) if (PATS[k] == l) r = k;
        return r;
    endfunction

    function automatic bit step_allowed(input int a, input int b);
        bit ok = 0;
        for (int k = 0; k < 7; k++) if (STEPS[k] == a * 10 + b) ok = 1;
        return ok;
    endfunction

    task automatic model_step(input logic [7:0] l, input logic clr, input logic rst);
        int p, lim, code;
        bit ped;
        if (rst) begin
            m_prev = 7; m_track = 0; m_run = 0; m_len = 0; m_timed = 0;
            m_cycles = 0; m_peds = 0;
            e_phase = 0; e_fault = 0; e_code = 0; e_ped = 0;
        end else begin
            p = decode_model(l);
            code = 0;
            ped = 0;
            lim = (m_run == 0 && !m_timed) ? 0 : REQ[m_run];
            if (p == 7) code = 1;
            else if (!m_track) begin
                if (p != m_prev) begin
                    m_track = 1; m_run = p; m_len = 1; m_timed = 0;
                end
            end else if (p == m_run) begin
                if (lim != 0 && m_len + 1 > lim) code = 3;
                else m_len++;
            end else if (lim != 0 && m_len < lim) code = 3;
            else if (!step_allowed(m_run, p)) code = 2;
            else begin
                if (m_run == 5) begin ped = 1; m_cycles++; end
                if (m_run == 4 && p == 1) m_cycles++;
                m_timed = (m_run == 5);
                m_run = p;
                m_len = 1;
            end
            if (code != 0) begin
                m_track = 0;
                if (!e_fault || clr) e_code = code;
                e_fault = 1;
            end else if (clr) begin
                e_fault = 0;
                e_code = 0;
            end
            m_prev = p;
            e_phase = p;
            e_ped = ped;
            m_peds += int'(ped);
        end
    endtask

    task automatic apply(input logic [7:0] l, input logic clr, input logic rst);
        {r1v, r1a, r1g, r2v, r2a, r2g, pv, pg} = l;
        clr_fault = clr;
        reset = rst;
        @(posedge clk);
        #1;
        model_step(l, clr, rst);
    endtask

    task automatic play(input int ph, input int n);
        for (int i = 0; i < n; i++) apply(pat(ph), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(8'hFF, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs, 7'd0);
        end
    endtask

    task automatic test_clean_sequence();
        int segp [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        int segn [8] = '{3, 1, 2, 4, 2, 5, 1, 1};
        int peds = 0;
        apply(pat(0), 1'b0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < segn[s]; i++) begin
                apply(pat(segp[s]), 1'b0, 1'b0);
                peds += int'(ped_served);
                n_cmp++;
                if (obs !== expv() || fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clean seg %0d: got %b want %b", s, obs, expv());
                end
                if (s == 6) begin
                    n_cmp++;
                    if (ped_served !== 1'b1) begin
                        n_bad++;
                        $display("FAIL clean_ped_pulse: got %b want 1", ped_served);
                    end
                end
            end
        end
        n_cmp++;
        if (peds !== 1) begin
            n_bad++;
            $display("FAIL clean_ped_count_pulses: got %0d want 1", peds);
        end
`ifdef SINALEIRA_MONITOR_STATS_EN
        n_cmp++;
        if (ped_count !== 8'd1 || cycle_count !== 8'd1) begin
            n_bad++;
            $display("FAIL clean_stats: got ped %0d cyc %0d want 1 1", ped_count, cycle_count);
        end
`endif
    endtask

    task automatic test_illegal();
        apply(pat(0), 1'b0, 1'b1);
        play(0, 1); play(1, 1); play(2, 2); play(3, 2);
        apply(pat(3) | 8'b00100000, 1'b0, 1'b0);
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || phase !== 3'd7 || obs !== expv()) begin
            n_bad++;
            $display("FAIL illegal: got f=%b c=%b p=%0d want f=1 c=01 p=7", fault, fault_code, phase);
        end
    endtask

    task automatic test_bad_transition();
        apply(pat(0), 1'b0, 1'b1);
        play(1, 1);
        play(3, 1);
        n_cmp++;
        if (fault_code !== 2'b10 || obs !== expv()) begin
            n_bad++;
            $display("FAIL bad_transition: got %b want code 10 (%b)", obs, expv());
        end
    endtask

    task automatic test_dwell_long();
        apply(pat(0), 1'b0, 1'b1);
        play(0, 1); play(1, 1); play(2, 2); play(3, 4);
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL dwell_long_early: got fault %b want 0", fault);
        end
        play(3, 1);
        n_cmp++;
        if (fault_code !== 2'b11 || obs !== expv()) begin
            n_bad++;
            $display("FAIL dwell_long: got %b want code 11 (%b)", obs, expv());
        end
    endtask

    task automatic test_dwell_short();
        apply(pat(0), 1'b0, 1'b1);
        play(0, 1); play(1, 1); play(2, 2); play(3, 3); play(4, 1);
        n_cmp++;
        if (fault_code !== 2'b11 || obs !== expv()) begin
            n_bad++;
            $display("FAIL dwell_short: got %b want code 11 (%b)", obs, expv());
        end
    endtask

    task automatic test_clr_collision();
        apply(pat(0), 1'b0, 1'b1);
        play(1, 1);
        play(3, 1);
        apply(8'hFF, 1'b1, 1'b0);
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || obs !== expv()) begin
            n_bad++;
            $display("FAIL clr_collision: got f=%b c=%b want f=1 c=01", fault, fault_code);
        end
    endtask

    task automatic test_clr_recovery();
        int segp [6] = '{0, 1, 2, 3, 4, 1};
        int segn [6] = '{2, 1, 2, 4, 2, 1};
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < segn[s]; i++) begin
                apply(pat(segp[s]), (s == 0 && i == 0), 1'b0);
                n_cmp++;
                if (obs !== expv() || fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clr_recovery seg %0d: got %b want %b", s, obs, expv());
                end
            end
        end
    endtask

    task automatic test_reset_mid_pg();
        apply(pat(0), 1'b0, 1'b1);
        play(2, 1); play(3, 4); play(4, 2); play(5, 2);
        apply(pat(5), 1'b1, 1'b1);
        n_cmp++;
        if (obs !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_mid_pg: got %b want 0", obs);
        end
`ifdef SINALEIRA_MONITOR_STATS_EN
        n_cmp++;
        if (ped_count !== 8'd0 || cycle_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_stats: got %0d %0d want 0 0", ped_count, cycle_count);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            apply(pat(i == 0 ? 1 : 2), 1'b0, 1'b0);
            n_cmp++;
            if (fault !== 1'b0 || obs !== expv()) begin
                n_bad++;
                $display("FAIL reset_resume cyc %0d: got %b want %b", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        int ph, len;
        logic [7:0] l;
        apply(pat(0), 1'b0, 1'b1);
        ph = 0;
        repeat (120) begin
            len = (ph == 0 && !m_timed) ? int'($urandom_range(1, 3)) : REQ[ph];
            if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 1 || len == 1) ? len + 1 : len - 1;
            for (int i = 0; i < len; i++) begin
                l = pat(ph);
                if ($urandom_range(0, 49) == 0) l = l ^ 8'(1 << $urandom_range(0, 7));
                apply(l, ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
                n_cmp++;
                if (obs !== expv()) begin
                    n_bad++;
                    $display("FAIL random: got %b want %b", obs, expv());
                end
`ifdef SINALEIRA_MONITOR_STATS_EN
                n_cmp++;
                if (ped_count !== 8'(m_peds) || cycle_count !== 8'(m_cycles)) begin
                    n_bad++;
                    $display("FAIL random_stats: got %0d %0d want %0d %0d",
                             ped_count, cycle_count, m_peds % 256, m_cycles % 256);
                end
`endif
            end
            case (ph)
                0: ph = 1;
                1: ph = 2;
                2: ph = 3;
                3: ph = 4;
                4: ph = ($urandom_range(0, 1) == 1) ? 5 : 1;
                default: ph = 0;
            endcase
            if ($urandom_range(0, 9) == 0) ph = int'($urandom_range(0, 5));
        end
    endtask

    initial begin
        model_step(8'h00, 1'b0, 1'b1);
        test_reset();
        test_clean_sequence();
        test_illegal();
        test_bad_transition();
        test_dwell_long();
        test_dwell_short();
        test_clr_collision();
        test_clr_recovery();
        test_reset_mid_pg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sinaleira_monitor.md
SINALEIRA_MONITOR -- requirements
Module: sinaleira_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_S1G, 1, required dwell of street-1 green, in cycles.
- T_YEL, 2, required dwell of either yellow, in cycles.
- T_S2G, 4, required dwell of street-2 green, in cycles.
- T_PED, 5, required dwell of pedestrian green, in cycles.
- T_ALLRED, 1, required dwell of all-red after pedestrian green, in cycles.
- All parameters are in the range 1..14.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- rua_1_vermelho / rua_1_amarelo / rua_1_verde, in, 1 each, street-1 lamps under observation.
- rua_2_vermelho / rua_2_amarelo / rua_2_verde, in, 1 each, street-2 lamps.
- pedestre_vermelho / pedestre_verde, in, 1 each, pedestrian lamps.
- clr_fault, in, 1, clears the sticky fault.
- phase, out, 3, registered decoded phase.
- fault, out, 1, sticky fault flag.
- fault_code, out, 2, cause of the first fault: 01 illegal, 10 bad transition, 11 dwell.
- ped_served, out, 1, one-cycle pulse when a pedestrian phase completes correctly.

Function
REQ-003 Each cycle, the 8 lamp inputs SHALL be decoded into exactly one phase:
- ALLRED=0: both reds and pedestrian red on, everything else off.
- S1G=1: rua_1_verde, rua_2_vermelho and pedestre_vermelho on, everything else off.
- S1Y=2: rua_1_amarelo, rua_2_vermelho and pedestre_vermelho on, everything else off.
- S2G=3: rua_2_verde, rua_1_vermelho and pedestre_vermelho on, everything else off.
- S2Y=4: rua_2_amarelo, rua_1_vermelho and pedestre_vermelho on, everything else off.
- PG=5: pedestre_verde and both street reds on, everything else off.
- ILLEGAL=7: any other combination.
REQ-004 phase SHALL present the decode of the previous cycle's inputs (1-cycle latency).
REQ-005 The control FSM SHALL have states SYNC and TRACK, plus a 4-bit dwell counter (saturating at 15) and a last-phase register.
REQ-006 SYNC behaviour:
- The FSM leaves SYNC for TRACK on the first cycle whose decoded phase is legal and differs from the previous cycle's decode.
- On that cycle it loads last-phase with the new phase and sets dwell=1.
- No checks are made while in SYNC.
REQ-007 Legal TRACK transitions SHALL be exactly: ALLRED->S1G, S1G->S1Y, S1Y->S2G, S2G->S2Y, S2Y->S1G, S2Y->PG, PG->ALLRED.
REQ-008 In TRACK, an unchanged phase SHALL increment dwell.
REQ-009 In TRACK, if dwell would exceed the phase's required value, a dwell fault (11) SHALL be raised on that cycle.
REQ-010 In TRACK, on a phase change:
- If dwell < the required value of the old phase, raise a dwell fault (11).
- Else, if the transition is not listed in REQ-007, raise a bad-transition fault (10).
- Else, load the new phase and set dwell=1.
REQ-011 Any ILLEGAL decode SHALL raise fault code 01, regardless of FSM state, and this takes priority over all other causes.
REQ-012 On any fault, the FSM SHALL enter SYNC.
REQ-013 Fault flag and code behaviour:
- fault is set one cycle after the offending sample.
- fault_code captures only the first fault and holds until cleared.
- Later faults re-enter SYNC but do not overwrite fault_code.
REQ-014 clr_fault SHALL clear fault and fault_code to 00 on the next edge. If a new fault is detected in the same cycle, the new fault SHALL win and load its code.
REQ-015 ped_served SHALL pulse high for 1 cycle, one cycle after a legal PG->ALLRED transition with correct PG dwell.
REQ-016 ALLRED dwell SHALL be checked only when ALLRED was entered from PG. ALLRED entered via SYNC has unbounded dwell.

Reset
REQ-017 While reset is high at a clock edge:
- phase=0, fault=0, fault_code=00, ped_served=0.
- dwell=0, FSM=SYNC.
- The previous-decode register is set to ILLEGAL, so the first legal sample after reset counts as a change.
REQ-018 Reset asserted mid-phase or mid-fault SHALL discard all history. Reset SHALL take priority over clr_fault and all detection.

Configuration
REQ-019 With SINALEIRA_MONITOR_STATS_EN defined, the block SHALL add two 8-bit outputs:
- cycle_count: increments on each legal S2Y->S1G or PG->ALLRED transition.
- ped_count: increments with each ped_served pulse.
- Both wrap 255->0 and reset to 0.
REQ-020 Without SINALEIRA_MONITOR_STATS_EN, those ports and counters SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Clean sequence, default parameters: ALLRED 3, S1G 1, S1Y 2, S2G 4, S2Y 2, PG 5, ALLRED 1, S1G. Required: fault=0 throughout; ped_served high exactly 1 cycle after the ALLRED sample; ped_count=1 with the macro defined.
- rua_1_verde and rua_2_verde both high for 1 cycle during S2G. Required: next cycle fault=1, fault_code=01, phase=7.
- S1G for 1 cycle, then directly S2G. Required: fault_code=10.
- S2G held 5 cycles. Required: fault_code=11 one cycle after the 5th sample.
- S2G held only 3 cycles before S2Y. Required: fault_code=11.
- Fault pending, then clr_fault pulsed for 1 cycle in the same cycle as an illegal sample. Required: fault stays 1 and fault_code=01.
- After a fault, a clean sequence with clr_fault pulsed. Required: fault=0 and no new fault.
- Reset asserted mid-PG. Required: all outputs 0 on the next edge; resumed S1G produces no fault.
